shift_add_multiplier: RTL and testbench

Multi-cycle unsigned multiplier for the ALU arithmetic section. It computes one partial product per clock using a WIDTH-bit ripple-carry adder built from `fulladder` instances. The block accepts operands from the ALU operand registers on a start pulse and returns a 2*WIDTH-bit product with a one-cycle done pulse. It is the sequential consumer of the full-adder sum/carry chain and trades WIDTH+1 cycles of latency for a single adder row.

---
 rtl/shift_add_multiplier.sv | 121 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 130 +++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock
// through a single row of full-adder cells, WIDTH cycles from start to done.

module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   mcand_reg, mcand_next;
   logic [2*WIDTH-1:0] acc_reg, acc_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic [2*WIDTH-1:0] product_reg, product_next;

   logic [WIDTH-1:0]   hi, lo;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH:0]     carry;
   logic [2*WIDTH-1:0] shifted;
   logic               last_iter;

   assign hi = acc_reg[2*WIDTH-1:WIDTH];
   assign lo = acc_reg[WIDTH-1:0];

   // hi + mcand as a ripple chain; carry[WIDTH] becomes the new top bit
   assign carry[0] = 1'b0;
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_adder
         fulladder u_fa (
            .a    (hi[gi]),
            .b    (mcand_reg[gi]),
            .cin  (carry[gi]),
            .sum  (sum[gi]),
            .cout (carry[gi+1])
         );
      end
   endgenerate

   assign shifted   = lo[0] ? {carry[WIDTH], sum, lo[WIDTH-1:1]}
                            : {1'b0, hi, lo[WIDTH-1:1]};
   assign last_iter = (cnt_reg == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         mcand_reg   <= '0;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         product_reg <= '0;
      end else begin
         state_reg   <= state_next;
         mcand_reg   <= mcand_next;
         acc_reg     <= acc_next;
         cnt_reg     <= cnt_next;
         product_reg <= product_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      mcand_next   = mcand_reg;
      acc_next     = acc_reg;
      cnt_next     = cnt_reg;
      product_next = product_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               mcand_next = a;
               acc_next   = {{WIDTH{1'b0}}, b};
               cnt_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            acc_next = shifted;
            cnt_next = cnt_reg + CW'(1);
            // Product is captured on the final iteration so it is valid alongside done
            if (last_iter) begin
               product_next = shifted;
               state_next   = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy    = (state_reg != IDLE);
   assign done    = (state_reg == DONE);
   assign product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized and directed self-checking bench for shift_add_multiplier against
// a plain arithmetic model (product = a*b, start ignored while busy).

module tb_shift_add_multiplier;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   a, b;
   logic           busy, done;
   logic [2*W-1:0] product;

   int total = 0;
   int bad   = 0;
   int done_count = 0;

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_count++;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after done falls.
   // ign_cycle > 0 pulses a competing start (0xFF*0xFF) in that cycle of the run.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int ign_cycle);
      logic [2*W-1:0] prev;
      int lat;
      int dc0;
      prev  = product;
      dc0   = done_count;
      start = 1'b1; a = x; b = y;
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom);
      check("busy_rise", 32'(busy), 32'd1);
      check("product_hold", 32'(product), 32'(prev));
      lat = 0;
      while (!done && lat < 50) begin
         @(negedge clk);
         lat++;
         start = 1'b0;
         if (lat == ign_cycle) begin
            start = 1'b1; a = 8'hFF; b = 8'hFF;
         end
      end
      start = 1'b0;
      check("latency", 32'(lat), 32'(W));
      check("product", 32'(product), 32'(int'(x) * int'(y)));
      check("busy_at_done", 32'(busy), 32'd1);
      @(negedge clk);
      check("done_width", 32'(done), 32'd0);
      check("busy_fall", 32'(busy), 32'd0);
      check("done_pulses", 32'(done_count - dc0), 32'd1);
      $display("op a=0x%02h b=0x%02h -> product=0x%04h latency=%0d", x, y, product, lat);
   endtask

   initial begin
      int dc0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(8'h0F, 8'h0F, 0);
      run_op(8'hFF, 8'hFF, 0);
      run_op(8'h00, 8'hA5, 0);
      run_op(8'h37, 8'h00, 0);

      // competing start during the run must be ignored
      run_op(8'h12, 8'h34, 2);
      dc0 = done_count;
      repeat (12) @(negedge clk);
      check("ignored_no_extra_done", 32'(done_count - dc0), 32'd0);
      check("ignored_idle", 32'(busy), 32'd0);

      // reset mid-run aborts with no done pulse
      dc0 = done_count;
      start = 1'b1; a = 8'hAB; b = 8'hCD;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_product", 32'(product), 32'd0);
      repeat (12) @(negedge clk);
      check("abort_no_done", 32'(done_count - dc0), 32'd0);
      $display("abort a=0xAB b=0xCD -> busy=%0d product=0x%04h", busy, product);
      run_op(8'h03, 8'h05, 0);

      // back-to-back: each run_op starts in the cycle done has just fallen
      run_op(8'h80, 8'h02, 0);
      run_op(8'h7F, 8'h81, 0);

      // reset asserted together with start: reset wins
      rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rst_wins_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 20; i++) begin
         run_op(W'($urandom), W'($urandom), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
